// File: rtl/uart_selftest_io.sv
// UART self-test sequencer: posts A000, sends a fixed 8N1 message,
// then posts AB00 and raises done.
module uart_selftest_io #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int START_DELAY  = 64
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        hk_csb,
  output logic [15:0] checkbits,
  output logic        uart_tx,
  output logic        done
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_START,
    S_SEND,
    S_DONE
  } state_t;

  // message sits in the top 26 bytes; low pad keeps idx 26 in range
  localparam logic [255:0] MSG =
    {"Monitor: Test UART passed\n", 48'h0};

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DLY_LAST  = 16'(START_DELAY - 1);
  localparam logic [4:0]  N_BYTES   = 5'd26;

  state_t      r_state;
  logic [15:0] r_dly;
  logic [15:0] r_baud;
  logic [3:0]  r_bit;
  logic [4:0]  r_idx;
  logic        r_busy;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic [15:0] r_check;
  logic        r_done;

  logic [7:0]  w_sel;
  logic [7:0]  w_byte;

  assign w_sel  = {5'd31 - r_idx, 3'b000};
  assign w_byte = MSG[w_sel +: 8];

  assign checkbits = r_check;
  assign uart_tx   = r_tx;
  assign done      = r_done;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_WAIT;
      r_dly   <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_check <= 16'h0000;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_WAIT: begin
          if (!hk_csb) begin
            r_dly <= '0;
          end else if (r_dly == DLY_LAST) begin
            r_dly   <= '0;
            r_state <= S_START;
          end else begin
            r_dly <= r_dly + 16'd1;
          end
        end
        S_START: begin
          r_check <= 16'hA000;
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (!r_busy) begin
            // idle between frames until SPI is released
            if (hk_csb) begin
              r_busy  <= 1'b1;
              r_bit   <= '0;
              r_baud  <= '0;
              r_tx    <= 1'b0;
              r_shift <= w_byte;
              r_idx   <= r_idx + 5'd1;
            end
          end else if (r_baud != BAUD_LAST) begin
            r_baud <= r_baud + 16'd1;
          end else begin
            r_baud <= '0;
            if (r_bit != 4'd9) begin
              // stop bit falls out of the 1-filled shifter
              r_tx    <= r_shift[0];
              r_shift <= {1'b1, r_shift[7:1]};
              r_bit   <= r_bit + 4'd1;
            end else if (r_idx == N_BYTES) begin
              r_busy  <= 1'b0;
              r_tx    <= 1'b1;
              r_check <= 16'hAB00;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (hk_csb) begin
              r_bit   <= '0;
              r_tx    <= 1'b0;
              r_shift <= w_byte;
              r_idx   <= r_idx + 5'd1;
            end else begin
              r_busy <= 1'b0;
              r_tx   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_selftest_io.sv
// Bench for uart_selftest_io: UART monitor decodes the message
// against the expected string; random pauses and aborts.
module tb_uart_selftest_io;

  localparam int C  = 4;
  localparam int SD = 8;
  localparam int N  = 26;

  logic        clock  = 1'b0;
  logic        resetb = 1'b0;
  logic        hk_csb = 1'b1;
  logic [15:0] checkbits;
  logic        uart_tx;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rx_count;
  int hk_rise;
  int start_cyc [N];
  byte unsigned exp_msg [N];

  uart_selftest_io #(
    .CLKS_PER_BIT(C),
    .START_DELAY (SD)
  ) dut (
    .clock    (clock),
    .resetb   (resetb),
    .hk_csb   (hk_csb),
    .checkbits(checkbits),
    .uart_tx  (uart_tx),
    .done     (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_cb"}, 32'(checkbits), 32'h0000);
    chk({tag, "_tx"}, 32'(uart_tx), 32'h1);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  task automatic apply_reset(input logic hk);
    resetb = 1'b0;
    hk_csb = hk;
    steps(3);
    resetb = 1'b1;
  endtask

  task automatic wait_a000(output int n);
    n = 0;
    while (checkbits !== 16'hA000 && n < 200) begin
      step();
      n++;
    end
  endtask

  // bit-midpoint sampling monitor for the whole message
  task automatic recv_msg();
    logic [7:0] b;
    int t;
    for (int i = 0; i < N; i++) begin
      t = 0;
      while (uart_tx !== 1'b0 && t < 2000) begin
        step();
        t++;
      end
      if (t >= 2000) begin
        chk("rx_timeout", 32'(i), 32'(N));
        return;
      end
      start_cyc[i] = cyc;
      steps(C / 2);
      chk("start_bit", 32'(uart_tx), 32'h0);
      for (int j = 0; j < 8; j++) begin
        steps(C);
        b[j] = uart_tx;
      end
      steps(C);
      chk("stop_bit", 32'(uart_tx), 32'h1);
      chk($sformatf("byte%0d", i), 32'(b),
          32'(exp_msg[i]));
      rx_count = i + 1;
      steps(C - C / 2);
    end
  endtask

  initial begin
    string s;
    int n;
    int pause;
    int t0;
    bit bad;
    s = "Monitor: Test UART passed\n";
    for (int i = 0; i < N; i++) exp_msg[i] = s[i];

    // reset and clean run
    resetb = 1'b0;
    steps(4);
    idle_chk("reset");
    resetb = 1'b1;
    wait_a000(n);
    chk("a000_delay", 32'(n), 32'(SD + 1));
    step();
    chk("first_start", 32'(uart_tx), 32'h0);
    t0 = cyc;
    rx_count = 0;
    recv_msg();
    chk("send_len", 32'(cyc - t0), 32'(N * 10 * C));
    chk("pass_cb", 32'(checkbits), 32'hAB00);
    chk("pass_done", 32'(done), 32'h1);
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      hk_csb = 1'($urandom);
      step();
      if (checkbits !== 16'hAB00 || done !== 1'b1 ||
          uart_tx !== 1'b1)
        bad = 1'b1;
    end
    chk("pass_hold", 32'(bad), 32'h0);

    // pause during byte 3
    apply_reset(1'b1);
    wait_a000(n);
    chk("a000_delay2", 32'(n), 32'(SD + 1));
    rx_count = 0;
    hk_rise = 0;
    pause = $urandom_range(8 * C, 8 * C + 40);
    fork
      recv_msg();
      begin
        wait (rx_count == 3);
        steps(C / 2 + 3 * C);
        hk_csb = 1'b0;
        steps(pause);
        hk_csb = 1'b1;
        hk_rise = cyc;
      end
    join
    chk("b3_to_b4_gap",
        32'(start_cyc[4] - start_cyc[3] > 10 * C), 32'h1);
    chk("b4_resume", 32'(start_cyc[4]), 32'(hk_rise + 1));
    chk("pause_pass_cb", 32'(checkbits), 32'hAB00);
    chk("pause_pass_done", 32'(done), 32'h1);

    // asynchronous abort mid-message
    apply_reset(1'b1);
    wait_a000(n);
    steps($urandom_range(5, 300));
    #2;
    resetb = 1'b0;
    #1;
    idle_chk("abort");

    // hk_csb held low blocks start
    apply_reset(1'b0);
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (checkbits !== 16'h0000 || uart_tx !== 1'b1)
        bad = 1'b1;
    end
    chk("hk_low_hold", 32'(bad), 32'h0);
    hk_csb = 1'b1;
    wait_a000(n);
    chk("a000_after_hk", 32'(n), 32'(SD + 1));
    rx_count = 0;
    recv_msg();
    chk("final_cb", 32'(checkbits), 32'hAB00);
    chk("final_done", 32'(done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_selftest_io.md
Name: uart_selftest_io

Overview:
- Self-contained UART self-test sequencer that drives a 16-bit checkpoint bus and a serial TX line.
- Runs the user-I/O UART test flow: announce start on checkbits, transmit a fixed ASCII message 8N1, then announce pass.
- Sits behind the user-project I/O pads. checkbits drive mprj_io[31:16], uart_tx drives mprj_io[6], hk_csb is sampled from mprj_io[3].

Parameters:
- CLKS_PER_BIT, 4167, clock cycles per UART bit (40 MHz / 9600 baud); legal range 2..65535.
- START_DELAY, 64, cycles to wait after reset release (with hk_csb high) before the test starts; legal range 1..65535.

Ports:
- clock  in  1  system clock, single domain, rising edge.
- resetb  in  1  asynchronous active-low reset.
- hk_csb  in  1  housekeeping SPI chip select; 1 = SPI idle, test may proceed.
- checkbits  out  16  test status word.
- uart_tx  out  1  UART serial output, idle high.
- done  out  1  high once the pass word is posted.

Behaviour:
- Reset: resetb low asynchronously forces checkbits=16'h0000, uart_tx=1, done=0, state WAIT, all counters 0.
  - Reset asserted mid-frame aborts immediately; no partial-frame recovery.
- States: WAIT -> START -> SEND -> DONE.
- WAIT:
  - Counter increments each cycle while hk_csb=1; it clears whenever hk_csb=0.
  - When the counter reaches START_DELAY, go to START.
- START (1 cycle): checkbits<=16'hA000, byte index<=0, go to SEND.
- Message ROM: fixed 26-byte string "Monitor: Test UART passed" followed by 0x0A.
- SEND, per byte, 8N1, LSB first:
  - Start bit 0, then data bits d0..d7, then stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
  - The first start bit begins on the cycle after checkbits becomes A000.
  - Consecutive bytes are back-to-back, with no idle gap between a stop bit and the next start bit.
- hk_csb=0 during SEND:
  - The current frame always completes.
  - The next frame does not start until hk_csb=1; uart_tx stays 1 while paused.
- After the stop bit of byte 25 (0x0A) completes: checkbits<=16'hAB00, done<=1, state DONE.
- DONE is terminal until reset; hk_csb is ignored; uart_tx=1; checkbits is held at AB00.
- checkbits takes only the values 0000, A000, AB00, in that order, each change being a single-cycle transition.
- All outputs are registered, so uart_tx is glitch-free.
- Baud counter width is 16 bits; the bit index is 4 bits (0..9).

Test Plan:
- Reset and idle:
  - Stimulus: hold resetb=0, hk_csb=1.
  - Required: checkbits=0000, uart_tx=1, done=0.
  - Then assert resetb=0 asynchronously mid-frame: outputs return to these values within the same cycle.
- Start timing:
  - Stimulus: CLKS_PER_BIT=4, START_DELAY=8, release reset with hk_csb=1.
  - Required: checkbits=A000 about 9 cycles later, then uart_tx falls on the next cycle.
- Frame decode:
  - Stimulus: sample uart_tx at each bit midpoint.
  - Required: the bench UART decodes exactly "Monitor: Test UART passed\n" (26 bytes, each with start=0 and stop=1).
  - Total SEND duration is 26*10*4 = 1040 cycles.
- Pass:
  - Required: one cycle after the final stop bit, checkbits=AB00 and done=1.
  - Both stay stable for 1000 further cycles with uart_tx=1.
- hk_csb gating:
  - Stimulus: hold hk_csb=0 after reset. Required: checkbits stays 0000 indefinitely.
  - Stimulus: drop hk_csb low mid-byte 3. Required: byte 3 finishes, line idles high, byte 4 starts after hk_csb returns high, and the full message is still correct.
- Default parameters:
  - Stimulus: 40 MHz clock, hk_csb=1.
  - Required: a 9600-baud monitor receives the message and AB00 appears within 1.5M cycles.
